ss_serializer: RTL and testbench
================================

SS_SERIALIZER -- requirements
Module: ss_serializer

Interface
REQ-001 Parameter WIDTH, default 8: number of data bits per frame, legal range 2..32.
REQ-002 clk  input  1  single rising-edge clock for all state.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 ena  input  1  global enable; low freezes all state except reset and the DONE exit.
REQ-005 data_in  input  WIDTH  parallel word to transmit.
REQ-006 load_valid  input  1  producer offers data_in this cycle.
REQ-007 load_ready  output  1  serializer can accept a word this cycle.
REQ-008 leri  input  1  shift direction, sampled only on load: 1 = left/MSB first, 0 = right/LSB first.
REQ-009 data_out  output  1  serial bit stream.
REQ-010 out_valid  output  1  data_out carries a frame bit this cycle.
REQ-011 busy  output  1  high in any state other than IDLE.
REQ-012 done  output  1  single-cycle pulse after the last frame bit.

Function
REQ-013 The block SHALL implement states IDLE, SHIFT, PAR (macro only) and DONE.
REQ-014 load_ready SHALL equal (state==IDLE) && ena && !rst.
REQ-015 Handshake: a word SHALL be accepted on a rising edge where load_valid && load_ready; data_in and leri are latched into the shift register and direction register, and the bit counter is cleared.
REQ-016 Acceptance in cycle N SHALL produce the first bit in cycle N+1, with out_valid=1.
REQ-017 In SHIFT, data_out SHALL be shreg[WIDTH-1] when the latched leri=1, and shreg[0] when it is 0.
REQ-018 In SHIFT with ena=1, each edge SHALL shift one position in the latched direction, zero-fill, and increment the counter.
REQ-019 At counter==WIDTH-1 with ena=1, the state SHALL go to PAR if compiled in, else to DONE.
REQ-020 With ena=0 in SHIFT or PAR, state, counter, shreg and data_out SHALL hold, and out_valid stays 1 (a stretched bit).
REQ-021 DONE SHALL last exactly one cycle regardless of ena: done=1, out_valid=0, data_out=0, then IDLE.
REQ-022 Frames are not back-to-back: a new load is accepted no earlier than the cycle after DONE.
REQ-023 Changes to leri or data_in after acceptance SHALL NOT affect the current frame.
REQ-024 In IDLE, data_out=0, out_valid=0 and done=0.
REQ-025 data_out, out_valid, busy and done SHALL be driven from registered state only, with no combinational path from load_valid, data_in or leri.
REQ-026 The counter SHALL be $clog2(WIDTH) bits wide and never wrap inside a frame.

Reset
REQ-027 rst=1 on an edge SHALL force IDLE and clear shreg, the counter and the direction register; this holds in any state, including mid-frame.
REQ-028 Reset values: data_out=0, out_valid=0, busy=0, done=0; load_ready=0 while rst is high.
REQ-029 A frame aborted by reset SHALL NOT generate done.

Configuration
REQ-030 SS_SERIALIZER_PARITY_EN defined: PAR state present; after the last data bit, one extra bit equal to the even parity (XOR) of the latched word is sent with out_valid=1, honouring ena stall; the frame is WIDTH+1 bits.
REQ-031 SS_SERIALIZER_PARITY_EN undefined: no PAR state and no parity logic; the frame is WIDTH bits.

Structure
REQ-032 Package ss_pkg SHALL hold the state enum (IDLE, SHIFT, PAR, DONE) and the constant SS_DEFAULT_WIDTH=8.
REQ-033 Sub-module ss_shift_core SHALL contain the loadable bidirectional shift register (load, shift, dir, q); the FSM, counter and parity logic stay in ss_serializer.

Verification
REQ-034 Load 0xB4 with leri=1, ena=1 -> data_out 1,0,1,1,0,1,0,0 over 8 cycles; done in cycle 9; load_ready back to 1 in cycle 10.
REQ-035 Load 0xB4 with leri=0 -> data_out 0,0,1,0,1,1,0,1; leri toggled mid-frame has no effect.
REQ-036 Load 0xFF with leri=1, drop ena for 3 cycles after bit 2 -> bit 2 held for 4 cycles; total 8 bits; done still one cycle.
REQ-037 Assert rst during bit 5 of 0x3C -> next cycle data_out=0, out_valid=0, busy=0, no done; a new load then accepted normally.
REQ-038 With parity enabled, load 0x07 with leri=0 -> bits 1,1,1,0,0,0,0,0 then parity 1; load 0xB4 -> parity bit 0.
REQ-039 Hold load_valid high continuously -> words accepted only in IDLE; each accepted word appears exactly once, with a gap for the DONE cycle.

Source files
------------

// File: rtl/ss_pkg.sv
// Shared types and constants for the ss_serializer block.
package ss_pkg;

    localparam int SS_DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        PAR   = 2'd2,
        DONE  = 2'd3
    } ss_state_e;

endpackage

// File: rtl/ss_shift_core.sv
// Loadable bidirectional shift register with zero fill; dir=1 shifts toward the MSB.
module ss_shift_core #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift,
    input  logic             dir,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end else if (shift) begin
            q <= dir ? {q[WIDTH-2:0], 1'b0} : {1'b0, q[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/ss_serializer.sv
// Parallel-to-serial frame transmitter with valid/ready load handshake and global enable.
// Optional trailing even-parity bit when SS_SERIALIZER_PARITY_EN is defined.
//
// state | meaning
// IDLE  | waiting for a word; load_ready follows ena
// SHIFT | one frame bit per enabled cycle, MSB or LSB first
// PAR   | parity bit (SS_SERIALIZER_PARITY_EN builds only)
// DONE  | one-cycle done pulse, then back to IDLE
module ss_serializer
    import ss_pkg::*;
#(
    parameter int WIDTH = SS_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic [WIDTH-1:0] data_in,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic             leri,
    output logic             data_out,
    output logic             out_valid,
    output logic             busy,
    output logic             done
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    ss_state_e        state;
    ss_state_e        state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             dir_q;
    logic [WIDTH-1:0] shreg;
    logic             accept;
    logic             shift_en;

    assign load_ready = (state == IDLE) && ena && !rst;
    assign accept     = load_valid && load_ready;
    assign shift_en   = (state == SHIFT) && ena;

    ss_shift_core #(
        .WIDTH (WIDTH)
    ) u_shift_core (
        .clk   (clk),
        .rst   (rst),
        .load  (accept),
        .shift (shift_en),
        .dir   (dir_q),
        .d     (data_in),
        .q     (shreg)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) state_nxt = SHIFT;
            end
            SHIFT: begin
                if (ena && cnt == CNT_LAST) begin
`ifdef SS_SERIALIZER_PARITY_EN
                    state_nxt = PAR;
`else
                    state_nxt = DONE;
`endif
                end
            end
            PAR: begin
`ifdef SS_SERIALIZER_PARITY_EN
                if (ena) state_nxt = DONE;
`else
                state_nxt = IDLE;
`endif
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Counter saturates on the last bit so it cannot wrap inside a frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt   <= '0;
            dir_q <= 1'b0;
        end else if (accept) begin
            cnt   <= '0;
            dir_q <= leri;
        end else if (shift_en && cnt != CNT_LAST) begin
            cnt <= cnt + 1'b1;
        end
    end

`ifdef SS_SERIALIZER_PARITY_EN
    logic par_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            par_q <= 1'b0;
        end else if (accept) begin
            par_q <= ^data_in;
        end
    end
`endif

    always_comb begin
        data_out  = 1'b0;
        out_valid = 1'b0;
        case (state)
            SHIFT: begin
                out_valid = 1'b1;
                data_out  = dir_q ? shreg[WIDTH-1] : shreg[0];
            end
`ifdef SS_SERIALIZER_PARITY_EN
            PAR: begin
                out_valid = 1'b1;
                data_out  = par_q;
            end
`endif
            default: ;
        endcase
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

endmodule

// File: tb/tb_ss_serializer.sv
// Self-checking bench for ss_serializer: queue-based frame model plus directed literal checks.
module tb_ss_serializer;

    localparam int W = 8;
`ifdef SS_SERIALIZER_PARITY_EN
    localparam int FB = W + 1;
`else
    localparam int FB = W;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         ena = 1'b0;
    logic         load_valid = 1'b0;
    logic         leri = 1'b0;
    logic [W-1:0] data_in = '0;
    logic         load_ready;
    logic         data_out;
    logic         out_valid;
    logic         busy;
    logic         done;

    ss_serializer #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .ena        (ena),
        .data_in    (data_in),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .leri       (leri),
        .data_out   (data_out),
        .out_valid  (out_valid),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;

    // Model: pending frame bits in transmit order, plus a pending-done flag.
    bit mq[$];
    bit m_done = 1'b0;
    bit chk_on = 1'b0;
    bit m_ev, m_ed, m_idle;

    logic [63:0] obs;
    int obs_n = 0;
    int ov_n = 0;
    int done_n = 0;
    bit done_seen = 1'b0;
    int done_cyc = 0;
    int acc_cyc = 0;

    task automatic check1(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cycle %0d: got %b, expected %b", name, cyc, act, exp);
        end
    endtask

    task automatic checkv(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            mq.delete();
            m_done = 1'b0;
            chk_on = 1'b1;
        end else if (m_done) begin
            m_done = 1'b0;
        end else if (mq.size() > 0) begin
            if (ena) begin
                void'(mq.pop_front());
                if (mq.size() == 0) m_done = 1'b1;
            end
        end else if (ena && load_valid) begin
            for (int k = 0; k < W; k++) begin
                mq.push_back(leri ? data_in[W-1-k] : data_in[k]);
            end
`ifdef SS_SERIALIZER_PARITY_EN
            mq.push_back(^data_in);
`endif
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            m_ev   = (mq.size() > 0);
            m_ed   = m_ev ? mq[0] : 1'b0;
            m_idle = !m_ev && !m_done;
            check1("out_valid", out_valid, m_ev);
            check1("data_out", data_out, m_ed);
            check1("done", done, m_done);
            check1("busy", busy, m_ev || m_done);
            check1("load_ready", load_ready, m_idle && ena && !rst);
            if (out_valid === 1'b1) ov_n++;
            if (out_valid === 1'b1 && ena && !rst) begin
                obs = {obs[62:0], data_out};
                obs_n++;
            end
            if (done === 1'b1) begin
                done_seen = 1'b1;
                done_cyc  = cyc;
                done_n++;
            end
            if (load_valid && load_ready === 1'b1) acc_cyc = cyc;
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic start_frame(input logic [W-1:0] word, input logic dir);
        obs       = '0;
        obs_n     = 0;
        ov_n      = 0;
        done_n    = 0;
        done_seen = 1'b0;
        data_in    = word;
        leri       = dir;
        ena        = 1'b1;
        load_valid = 1'b1;
        step();
        load_valid = 1'b0;
        data_in    = W'($urandom);
    endtask

    task automatic wait_done();
        int i;
        i = 0;
        while (!done_seen && i < 60) begin
            step();
            i++;
        end
        check1("done_seen", done_seen, 1'b1);
    endtask

    logic [FB-1:0] exp_bits;

    initial begin
        rst = 1'b1;
        step();
        step();
        @(negedge clk);
        check1("rst_out_valid", out_valid, 1'b0);
        check1("rst_busy", busy, 1'b0);
        check1("rst_done", done, 1'b0);
        check1("rst_load_ready", load_ready, 1'b0);
        step();
        rst = 1'b0;
        ena = 1'b1;
        step();

        // 0xB4 MSB first
        start_frame(8'hB4, 1'b1);
        wait_done();
`ifdef SS_SERIALIZER_PARITY_EN
        exp_bits = {8'hB4, 1'b0};
`else
        exp_bits = 8'hB4;
`endif
        checkv("b4_msb_bits", 32'(obs[FB-1:0]), 32'(exp_bits));
        checkv("b4_msb_len", 32'(obs_n), 32'(FB));
        checkv("done_latency", 32'(done_cyc - acc_cyc), 32'(FB + 1));
        @(negedge clk);
        check1("ready_after_done", load_ready, 1'b1);
        step();

        // 0xB4 LSB first, leri toggled during the frame
        start_frame(8'hB4, 1'b0);
        for (int i = 0; i < 4; i++) begin
            leri = ~leri;
            step();
        end
        wait_done();
`ifdef SS_SERIALIZER_PARITY_EN
        exp_bits = {8'h2D, 1'b0};
`else
        exp_bits = 8'h2D;
`endif
        checkv("b4_lsb_bits", 32'(obs[FB-1:0]), 32'(exp_bits));
        step();

        // 0xFF with a three-cycle stall on bit 2
        start_frame(8'hFF, 1'b1);
        step();
        ena = 1'b0;
        step();
        step();
        step();
        ena = 1'b1;
        wait_done();
        checkv("stall_bits", 32'(obs_n), 32'(FB));
        checkv("stall_valid_cycles", 32'(ov_n), 32'(FB + 3));
        checkv("stall_done_pulses", 32'(done_n), 32'd1);
        step();

        // Reset during bit 5 of 0x3C
        start_frame(8'h3C, 1'b1);
        for (int i = 0; i < 4; i++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        check1("abort_data_out", data_out, 1'b0);
        check1("abort_out_valid", out_valid, 1'b0);
        check1("abort_busy", busy, 1'b0);
        for (int i = 0; i < 12; i++) step();
        checkv("abort_no_done", 32'(done_n), 32'd0);
        start_frame(8'h3C, 1'b0);
        wait_done();
`ifdef SS_SERIALIZER_PARITY_EN
        exp_bits = {8'h3C, 1'b0};
`else
        exp_bits = 8'h3C;
`endif
        checkv("after_abort_bits", 32'(obs[FB-1:0]), 32'(exp_bits));
        step();

`ifdef SS_SERIALIZER_PARITY_EN
        start_frame(8'h07, 1'b0);
        wait_done();
        checkv("par_07_bits", 32'(obs[FB-1:0]), 32'h1C1);
        step();
`endif

        // Continuous load_valid: back-to-back offers, accepted only in IDLE
        load_valid = 1'b1;
        done_n = 0;
        for (int i = 0; i < 1000; i++) begin
            data_in = W'($urandom);
            leri    = 1'($urandom);
            ena     = ($urandom_range(0, 4) != 0);
            step();
        end
        check1("stream_made_progress", (done_n > 10), 1'b1);

        // Fully random phase with occasional resets
        for (int i = 0; i < 3000; i++) begin
            data_in    = W'($urandom);
            leri       = 1'($urandom);
            load_valid = 1'($urandom);
            ena        = ($urandom_range(0, 4) != 0);
            rst        = ($urandom_range(0, 199) == 0);
            step();
        end
        rst = 1'b0;
        load_valid = 1'b0;
        ena = 1'b1;
        for (int i = 0; i < 20; i++) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
